// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared constants and types for the shift_pipe two-stage shift unit.
//
// Contents:
//   WIDTH, SHAMT_W, OP_W  data, shift-amount and opcode widths
//   OP_SLL/OP_SRA/OP_SRL  opcode encodings (OP_SRL only decoded when the
//                         SHIFT_PIPE_SRL_EN macro is defined)
//   s1_payload_t          stage-1 slice contents: op, upper shamt bits, data
//   s2_payload_t          stage-2 slice contents: op, final data
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 2;

  // Stage 1 consumes shamt[1:0]; the remaining bits ride along to stage 2.
  localparam int SHAMT_HI_W = SHAMT_W - 2;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRA = 2'b01;
  localparam logic [OP_W-1:0] OP_SRL = 2'b10;

  typedef logic [OP_W-1:0] op_t;

  typedef struct packed {
    op_t                   op;
    logic [SHAMT_HI_W-1:0] shamt_hi;
    logic [WIDTH-1:0]      data;
  } s1_payload_t;

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] data;
  } s2_payload_t;

endpackage

// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
// Generic valid/ready register slice with synchronous flush. The payload is an
// opaque vector; the parent packs data, shamt residue and op into it.
//
// Parameters:
//   W          payload width
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset; clears valid and payload
//   flush      synchronous kill of the held entry (beats any load)
//   i_valid    upstream valid
//   o_ready    slice can load this cycle (empty, or downstream draining)
//   i_payload  upstream payload
//   o_valid    slice holds a valid entry
//   i_ready    downstream accepts
//   o_payload  held payload
// -----------------------------------------------------------------------------
module shift_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_payload,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_payload
);

  logic         r_valid;
  logic [W-1:0] r_payload;
  logic         w_accept;

  assign w_accept  = !r_valid | i_ready;
  assign o_ready   = w_accept;
  assign o_valid   = r_valid;
  assign o_payload = r_payload;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= i_valid;
    end
  end

  // Payload is allowed to capture bubbles; only the valid bit must be exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_payload <= '0;
    end else if (w_accept) begin
      r_payload <= i_payload;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Two-stage pipelined 32-bit shifter for the ALU shift path.
//   Stage 1: shift-by-1 and shift-by-2 layers (shamt[1:0])
//   Stage 2: shift-by-4, 8 and 16 layers (shamt[4:2])
// Both stages are valid/ready slices so the unit can be stalled or flushed on
// its own.
//
// Build option:
//   SHIFT_PIPE_SRL_EN  defined: op 10 is a logical right shift, op 11 is sll.
//                      undefined: op[1] is ignored for the shift (10 -> sll,
//                      11 -> sra) and no logical-right-shift path exists.
//
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   flush                synchronous kill of every in-flight op
//   in_valid/in_ready    input handshake (in_ready independent of in_valid)
//   in_data, in_shamt    operand A and shift amount 0..31
//   in_op                00 sll, 01 sra, 10 srl (option), 11 reserved
//   out_valid/out_ready  result handshake
//   out_data, out_op     shifted result and the op that produced it
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_op
);

  s1_payload_t        w_s1_d;
  s1_payload_t        w_s1_q;
  s2_payload_t        w_s2_d;
  s2_payload_t        w_s2_q;
  logic               w_s1_valid;
  logic               w_s2_valid;
  logic               w_s1_accept;
  logic               w_s2_accept;
  logic [WIDTH-1:0]   w_s1_shifted;
  logic [WIDTH-1:0]   w_s2_shifted;
  logic [SHAMT_W-1:0] w_s2_amt;

  // Stage 1 shift: low two shamt bits. Right shifts fill from the operand MSB
  // for sra, so the sign is still sitting in bit 31 for stage 2 to replicate.
  always_comb begin
    w_s1_shifted = in_data << in_shamt[1:0];
`ifdef SHIFT_PIPE_SRL_EN
    if (in_op == OP_SRA) begin
      w_s1_shifted = $unsigned($signed(in_data) >>> in_shamt[1:0]);
    end else if (in_op == OP_SRL) begin
      w_s1_shifted = in_data >> in_shamt[1:0];
    end
`else
    if (in_op[0]) begin
      w_s1_shifted = $unsigned($signed(in_data) >>> in_shamt[1:0]);
    end
`endif
  end

  always_comb begin
    w_s1_d          = '0;
    w_s1_d.op       = in_op;
    w_s1_d.shamt_hi = in_shamt[SHAMT_W-1:2];
    w_s1_d.data     = w_s1_shifted;
  end

  shift_pipe_stage #(
    .W($bits(s1_payload_t))
  ) u_stage1 (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .i_valid   (in_valid),
    .o_ready   (w_s1_accept),
    .i_payload (w_s1_d),
    .o_valid   (w_s1_valid),
    .i_ready   (w_s2_accept),
    .o_payload (w_s1_q)
  );

  // Stage 2 shift: remaining bits, weighted by 4.
  assign w_s2_amt = {w_s1_q.shamt_hi, 2'b00};

  always_comb begin
    w_s2_shifted = w_s1_q.data << w_s2_amt;
`ifdef SHIFT_PIPE_SRL_EN
    if (w_s1_q.op == OP_SRA) begin
      w_s2_shifted = $unsigned($signed(w_s1_q.data) >>> w_s2_amt);
    end else if (w_s1_q.op == OP_SRL) begin
      w_s2_shifted = w_s1_q.data >> w_s2_amt;
    end
`else
    if (w_s1_q.op[0]) begin
      w_s2_shifted = $unsigned($signed(w_s1_q.data) >>> w_s2_amt);
    end
`endif
  end

  always_comb begin
    w_s2_d      = '0;
    w_s2_d.op   = w_s1_q.op;
    w_s2_d.data = w_s2_shifted;
  end

  shift_pipe_stage #(
    .W($bits(s2_payload_t))
  ) u_stage2 (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .i_valid   (w_s1_valid),
    .o_ready   (w_s2_accept),
    .i_payload (w_s2_d),
    .o_valid   (w_s2_valid),
    .i_ready   (out_ready),
    .o_payload (w_s2_q)
  );

  // During flush the pipe is emptied at the next edge, so advertise ready even
  // though the offered op will be dropped.
  assign in_ready  = w_s1_accept | flush;

  assign out_valid = w_s2_valid;
  assign out_data  = w_s2_q.data;
  assign out_op    = w_s2_q.op;

endmodule
